// File: rtl/rv32i_csr_access_unit_if.sv
// Request/response and CSR-file port bundle for the Zicsr access unit.
// master: execute stage plus CSR file (environment); slave: the access unit.
interface rv32i_csr_access_unit_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 12
);
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_csr_addr;
  logic [DATA_W-1:0] req_rs1_data;
  logic [4:0]        req_zimm;
  logic              req_rs1_is_x0;
  logic              req_rd_is_x0;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  logic              csr_re;
  logic [ADDR_W-1:0] csr_raddr;
  logic [DATA_W-1:0] csr_rdata;
  logic              csr_we;
  logic [ADDR_W-1:0] csr_waddr;
  logic [DATA_W-1:0] csr_wdata;

  modport master (
    output req_valid, req_funct3, req_csr_addr, req_rs1_data, req_zimm,
           req_rs1_is_x0, req_rd_is_x0, rsp_ready, csr_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           csr_re, csr_raddr, csr_we, csr_waddr, csr_wdata
  );

  modport slave (
    input  req_valid, req_funct3, req_csr_addr, req_rs1_data, req_zimm,
           req_rs1_is_x0, req_rd_is_x0, rsp_ready, csr_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           csr_re, csr_raddr, csr_we, csr_waddr, csr_wdata
  );
endinterface

// File: rtl/rv32i_csr_access_unit.sv
// Zicsr requester: sequences read / modify / write-back of one CSR per
// request against a CSR file with 1-cycle registered read data.
module rv32i_csr_access_unit #(
  parameter int unsigned CSR_NUM = 4096,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 12
) (
  input logic                      clk,
  input logic                      rst,
  rv32i_csr_access_unit_if.slave   bus
);

  typedef enum logic [2:0] {IDLE, READ, CAPTURE, WRITE, RESP} state_t;

  localparam logic [ADDR_W:0] CSR_LIMIT = CSR_NUM[ADDR_W:0];

  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        op_q;
  logic [DATA_W-1:0] src_q;
  logic [DATA_W-1:0] old_q;
  logic [DATA_W-1:0] new_q;
  logic              err_q;
  logic              we_q;

  logic [1:0]        op_in;
  logic              imm_in;
  logic [DATA_W-1:0] src_in;
  logic              is_rw_in;
  logic              wr_in;
  logic              rd_sup_in;
  logic              err_in;
  logic [DATA_W-1:0] mod_val;

  // Request decode, evaluated on the live request so IDLE can branch directly.
  always_comb begin
    op_in     = bus.req_funct3[1:0];
    imm_in    = bus.req_funct3[2];
    src_in    = imm_in ? {{(DATA_W-5){1'b0}}, bus.req_zimm} : bus.req_rs1_data;
    is_rw_in  = (op_in == 2'b01);
    wr_in     = is_rw_in || !(imm_in ? (bus.req_zimm == '0) : bus.req_rs1_is_x0);
    rd_sup_in = is_rw_in && bus.req_rd_is_x0;
    err_in    = (op_in == 2'b00)
             || ({1'b0, bus.req_csr_addr} >= CSR_LIMIT)
             || (wr_in && (bus.req_csr_addr[ADDR_W-1 -: 2] == 2'b11));
  end

  always_comb begin
    case (op_q)
      2'b01:   mod_val = src_q;
      2'b10:   mod_val = bus.csr_rdata | src_q;
      default: mod_val = bus.csr_rdata & ~src_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (bus.req_valid) begin
        if (err_in)         state_nx = RESP;
        else if (rd_sup_in) state_nx = WRITE;
        else                state_nx = READ;
      end
      READ:    state_nx = CAPTURE;
      CAPTURE: state_nx = we_q ? WRITE : RESP;
      WRITE:   state_nx = RESP;
      RESP:    if (bus.rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      op_q   <= '0;
      src_q  <= '0;
      old_q  <= '0;
      new_q  <= '0;
      err_q  <= 1'b0;
      we_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.req_valid) begin
          addr_q <= bus.req_csr_addr;
          op_q   <= op_in;
          src_q  <= src_in;
          new_q  <= src_in;
          old_q  <= '0;
          err_q  <= err_in;
          we_q   <= wr_in;
        end
        CAPTURE: begin
          old_q <= bus.csr_rdata;
          new_q <= mod_val;
        end
        default: ;
      endcase
    end
  end

  // Strobes are masked by rst so a reset landing mid-access issues nothing further.
  always_comb begin
    bus.req_ready = (state == IDLE) && !rst;
    bus.rsp_valid = (state == RESP) && !rst;
    bus.rsp_rdata = old_q;
    bus.rsp_err   = err_q;
    bus.csr_re    = (state == READ) && !rst;
    bus.csr_raddr = bus.csr_re ? addr_q : '0;
    bus.csr_we    = (state == WRITE) && !rst;
    bus.csr_waddr = bus.csr_we ? addr_q : '0;
    bus.csr_wdata = bus.csr_we ? new_q : '0;
  end

endmodule

// File: tb/tb_rv32i_csr_access_unit.sv
// Bench for rv32i_csr_access_unit: CSR-file environment, per-request
// reference model, directed scenarios and a randomized sweep.
module tb_rv32i_csr_access_unit;

  logic clk;
  logic rst;

  rv32i_csr_access_unit_if #(.DATA_W(32), .ADDR_W(12)) bus ();
  rv32i_csr_access_unit_if #(.DATA_W(32), .ADDR_W(12)) bus32 ();

  rv32i_csr_access_unit #(.CSR_NUM(4096), .DATA_W(32), .ADDR_W(12)) u_dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  rv32i_csr_access_unit #(.CSR_NUM(32), .DATA_W(32), .ADDR_W(12)) u_dut32 (
    .clk(clk), .rst(rst), .bus(bus32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // CSR file seen by the DUT, plus a backdoor used only for test setup.
  bit   [31:0] mem     [4096];
  bit   [31:0] ref_mem [4096];
  logic [31:0] rdata_q = '0;
  logic        bd_we = 1'b0;
  logic [11:0] bd_addr = '0;
  logic [31:0] bd_data = '0;

  always @(posedge clk) begin
    if (bd_we)           mem[bd_addr] <= bd_data;
    else if (bus.csr_we) mem[bus.csr_waddr] <= bus.csr_wdata;
    if (bus.csr_re)      rdata_q <= mem[bus.csr_raddr];
  end
  assign bus.csr_rdata   = rdata_q;
  assign bus32.csr_rdata = '0;

  int unsigned re_cnt = 0, we_cnt = 0, excl_cnt = 0;
  always @(negedge clk) begin
    if (bus.csr_re)                re_cnt   <= re_cnt + 1;
    if (bus.csr_we)                we_cnt   <= we_cnt + 1;
    if (bus.csr_re && bus.csr_we)  excl_cnt <= excl_cnt + 1;
  end

  logic [31:0] last_rdata;
  logic        last_err;
  int          last_lat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic bd_write(input logic [11:0] a, input logic [31:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(posedge clk); @(negedge clk);
    bd_we = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic do_req(input logic [2:0] f3, input logic [11:0] addr, input logic [31:0] rs1,
                        input logic [4:0] zimm, input logic rdx0, input int hold);
    logic        rs1x0, is_rw, wr, rd, illegal;
    logic [31:0] src, old, newv, exp_rdata;
    int          exp_lat, exp_re_at, exp_we_at, n, got_re_at, got_we_at, w;
    int unsigned re_b, we_b, x_b;
    logic [31:0] held;

    rs1x0   = f3[2] ? (zimm == 5'd0) : (rs1 == 32'd0);
    src     = f3[2] ? {27'd0, zimm} : rs1;
    is_rw   = (f3[1:0] == 2'b01);
    wr      = is_rw || !rs1x0;
    rd      = !(is_rw && rdx0);
    illegal = (f3[1:0] == 2'b00) || (wr && addr[11:10] == 2'b11);
    old     = ref_mem[addr];
    newv    = is_rw ? src : (f3[1:0] == 2'b10) ? (old | src) : (old & ~src);
    if (illegal) begin
      exp_rdata = '0; exp_lat = 1; exp_re_at = 0; exp_we_at = 0;
    end else begin
      exp_rdata = rd ? old : '0;
      exp_lat   = (rd && wr) ? 4 : rd ? 3 : 2;
      exp_re_at = rd ? 1 : 0;
      exp_we_at = wr ? (rd ? 3 : 1) : 0;
      if (wr) ref_mem[addr] = newv;
    end

    w = 0;
    while (!bus.req_ready && w < 20) begin @(negedge clk); w++; end
    chk("req_ready_idle", {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1; bus.req_funct3 = f3; bus.req_csr_addr = addr;
    bus.req_rs1_data = rs1; bus.req_zimm = zimm;
    bus.req_rs1_is_x0 = rs1x0; bus.req_rd_is_x0 = rdx0;
    re_b = re_cnt; we_b = we_cnt; x_b = excl_cnt;
    @(posedge clk); @(negedge clk);
    bus.req_valid = 1'b0; bus.req_funct3 = 3'($urandom); bus.req_csr_addr = 12'($urandom);
    bus.req_rs1_data = $urandom; bus.req_zimm = 5'($urandom);
    bus.req_rs1_is_x0 = 1'($urandom); bus.req_rd_is_x0 = 1'($urandom);

    n = 1; got_re_at = 0; got_we_at = 0;
    while (!bus.rsp_valid && n <= 8) begin
      if (bus.csr_re && got_re_at == 0) begin
        got_re_at = n; chk("csr_raddr", {20'd0, bus.csr_raddr}, {20'd0, addr});
      end
      if (bus.csr_we && got_we_at == 0) begin
        got_we_at = n;
        chk("csr_waddr", {20'd0, bus.csr_waddr}, {20'd0, addr});
        chk("csr_wdata", bus.csr_wdata, newv);
      end
      @(negedge clk); n++;
    end
    chk("latency", n, exp_lat);
    chk("re_offset", got_re_at, exp_re_at);
    chk("we_offset", got_we_at, exp_we_at);
    chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, illegal});
    chk("rsp_rdata", bus.rsp_rdata, exp_rdata);
    last_rdata = bus.rsp_rdata; last_err = bus.rsp_err; last_lat = n;
    held = bus.rsp_rdata;

    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, bus.rsp_valid}, 32'd1);
      chk("hold_rdata", bus.rsp_rdata, held);
      chk("hold_ready_low", {31'd0, bus.req_ready}, 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("rsp_valid_drop", {31'd0, bus.rsp_valid}, 32'd0);
    chk("idle_after_rsp", {31'd0, bus.req_ready}, 32'd1);
    chk("re_count", re_cnt - re_b, exp_re_at != 0 ? 1 : 0);
    chk("we_count", we_cnt - we_b, exp_we_at != 0 ? 1 : 0);
    chk("re_we_exclusive", excl_cnt - x_b, 0);
    chk("csr_content", mem[addr], ref_mem[addr]);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n, sre, swe;
    logic [11:0] a;
    logic [31:0] r;
    logic [4:0]  z;
    rst = 1'b1;
    bus.req_valid = 0; bus.req_funct3 = 0; bus.req_csr_addr = 0; bus.req_rs1_data = 0;
    bus.req_zimm = 0; bus.req_rs1_is_x0 = 0; bus.req_rd_is_x0 = 0; bus.rsp_ready = 0;
    bus32.req_valid = 0; bus32.req_funct3 = 0; bus32.req_csr_addr = 0; bus32.req_rs1_data = 0;
    bus32.req_zimm = 0; bus32.req_rs1_is_x0 = 0; bus32.req_rd_is_x0 = 0; bus32.rsp_ready = 1;

    @(negedge clk); @(negedge clk);
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_csr_re", {31'd0, bus.csr_re}, 32'd0);
    chk("rst_csr_we", {31'd0, bus.csr_we}, 32'd0);
    chk("rst_addrs", {8'd0, bus.csr_raddr, bus.csr_waddr}, 32'd0);
    chk("rst_wdata", bus.csr_wdata, 32'd0);
    rst = 1'b0;
    #1 chk("post_rst_ready", {31'd0, bus.req_ready}, 32'd1);
    @(negedge clk);

    // Directed scenarios with literal expectations pinning the model.
    bd_write(12'h005, 32'h11);
    do_req(3'b001, 12'h005, 32'hA5A5, 5'd0, 1'b0, 0);
    chk("pin_rw_old", last_rdata, 32'h11);
    chk("pin_rw_lat", last_lat, 4);
    chk("pin_rw_new", mem[12'h005], 32'hA5A5);

    bd_write(12'h010, 32'hFF);
    do_req(3'b111, 12'h010, 32'd0, 5'h03, 1'b0, 0);
    chk("pin_rci_old", last_rdata, 32'hFF);
    chk("pin_rci_new", mem[12'h010], 32'hFC);
    do_req(3'b010, 12'h010, 32'd0, 5'd0, 1'b0, 0);
    chk("pin_rs_x0_old", last_rdata, 32'hFC);
    chk("pin_rs_x0_lat", last_lat, 3);

    do_req(3'b001, 12'h020, 32'h1234, 5'd0, 1'b1, 0);
    chk("pin_wo_rdata", last_rdata, 32'd0);
    chk("pin_wo_lat", last_lat, 2);
    chk("pin_wo_mem", mem[12'h020], 32'h1234);

    do_req(3'b000, 12'h005, 32'h1, 5'd1, 1'b0, 0);
    chk("pin_f3_err", {31'd0, last_err}, 32'd1);
    chk("pin_f3_lat", last_lat, 1);
    do_req(3'b001, 12'hC00, 32'h55, 5'd0, 1'b0, 0);
    chk("pin_ro_err", {31'd0, last_err}, 32'd1);
    do_req(3'b010, 12'hC00, 32'd0, 5'd0, 1'b0, 0);
    chk("pin_ro_read_ok", {31'd0, last_err}, 32'd0);

    do_req(3'b001, 12'h005, 32'h600D, 5'd0, 1'b0, 5);
    chk("pin_hold_old", last_rdata, 32'hA5A5);

    // Reset while the read strobe is up: the request must vanish.
    bd_write(12'h030, 32'h77);
    bus.req_valid = 1'b1; bus.req_funct3 = 3'b001; bus.req_csr_addr = 12'h030;
    bus.req_rs1_data = 32'hDEAD; bus.req_rs1_is_x0 = 1'b0; bus.req_rd_is_x0 = 1'b0;
    @(posedge clk); @(negedge clk);
    bus.req_valid = 1'b0;
    chk("rstmid_in_read", {31'd0, bus.csr_re}, 32'd1);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("rstmid_ready_low", {31'd0, bus.req_ready}, 32'd0);
    chk("rstmid_rdata", bus.rsp_rdata, 32'd0);
    rst = 1'b0;
    #1 chk("rstmid_idle", {31'd0, bus.req_ready}, 32'd1);
    sre = 0; swe = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.csr_we) swe++;
      if (bus.rsp_valid) sre++;
      @(negedge clk);
    end
    chk("rstmid_no_we", swe, 0);
    chk("rstmid_no_rsp", sre, 0);
    chk("rstmid_mem", mem[12'h030], 32'h77);

    // Randomized sweep; a small address pool forces reuse and read-only hits.
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 5))
        0: a = 12'h005;
        1: a = 12'h010;
        2: a = 12'h020;
        3: a = 12'hC01;
        4: a = 12'h7FF;
        default: a = 12'($urandom);
      endcase
      r = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      z = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      do_req(3'($urandom), a, r, z, ($urandom_range(0, 3) == 0), $urandom_range(0, 3));
    end

    // Reduced CSR space: the first is out of range, the second is the last legal entry.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("d32_ready", {31'd0, bus32.req_ready}, 32'd1);
      bus32.req_valid = 1'b1; bus32.req_funct3 = 3'b010;
      bus32.req_csr_addr = (k == 0) ? 12'h040 : 12'h01F;
      bus32.req_rs1_data = 32'd0; bus32.req_rs1_is_x0 = 1'b1; bus32.req_rd_is_x0 = 1'b0;
      @(posedge clk); @(negedge clk);
      bus32.req_valid = 1'b0;
      n = 1; sre = 0; swe = 0;
      while (!bus32.rsp_valid && n < 8) begin
        if (bus32.csr_re) sre++;
        if (bus32.csr_we) swe++;
        @(negedge clk); n++;
      end
      chk("d32_err", {31'd0, bus32.rsp_err}, (k == 0) ? 32'd1 : 32'd0);
      chk("d32_lat", n, (k == 0) ? 1 : 3);
      chk("d32_re", sre, (k == 0) ? 0 : 1);
      chk("d32_we", swe, 0);
      chk("d32_rdata", bus32.rsp_rdata, 32'd0);
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv32i_csr_access_unit.md
Name: rv32i_csr_access_unit

Overview:
Requester side of the CSR register-file interface. It takes one decoded Zicsr instruction from the execute stage and sequences the access: read the old value, modify it, then write the new value back. It drives the CSR file's csr_re/csr_raddr/csr_we/csr_waddr/csr_wdata and consumes csr_rdata, which is registered with 1-cycle latency. It returns the old CSR value for rd through a valid/ready response.

Parameters:
CSR_NUM, 4096, number of implemented CSR entries; addresses >= CSR_NUM are illegal
DATA_W, 32, CSR/GPR data width
ADDR_W, 12, CSR address width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
req_valid  in  1  request present
req_ready  out  1  unit can accept a request
req_funct3  in  3  Zicsr funct3
req_csr_addr  in  12  target CSR
req_rs1_data  in  32  rs1 value (register forms)
req_zimm  in  5  immediate (I forms), zero-extended
req_rs1_is_x0  in  1  rs1 field == 0
req_rd_is_x0  in  1  rd field == 0
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_rdata  out  32  old CSR value for rd
rsp_err  out  1  illegal-instruction flag
csr_re  out  1  CSR read enable
csr_raddr  out  12  CSR read address
csr_rdata  in  32  CSR read data, valid the cycle after csr_re is sampled
csr_we  out  1  CSR write enable
csr_waddr  out  12  CSR write address
csr_wdata  out  32  CSR write data

Behaviour:
- One clock (clk); rst synchronous, active-high. On reset: state=IDLE; req_ready=0 during the reset cycle, then 1; rsp_valid=0, rsp_err=0, rsp_rdata=0, csr_re=0, csr_we=0, addresses and wdata=0.
- Source operand: src = req_rs1_data for funct3 001/010/011; src = {27'b0, req_zimm} for 101/110/111.
- Operations:
  - RW: new = src.
  - RS: new = old | src.
  - RC: new = old & ~src.
- Read suppression: RW/RWI with req_rd_is_x0=1 does not assert csr_re; rsp_rdata=0.
- Write suppression: RS/RC/RSI/RCI with req_rs1_is_x0=1 (zimm==0 for I forms) does not assert csr_we.
- Errors, checked at acceptance: funct3 000 or 100; addr >= CSR_NUM; a write that is not suppressed to addr[11:10]==2'b11 (read-only). An error produces no csr_re/csr_we, rsp_err=1, rsp_rdata=0.
- FSM states: IDLE, READ, CAPTURE, WRITE, RESP.
  - IDLE: req_ready=1. On req_valid, latch all request fields.
    - error -> RESP.
    - read suppressed -> WRITE (new=src).
    - otherwise -> READ.
  - READ: csr_re=1, csr_raddr=addr for exactly 1 cycle -> CAPTURE.
  - CAPTURE: register old_q=csr_rdata and new_q=f(old_q,src).
    - write needed -> WRITE.
    - otherwise -> RESP.
  - WRITE: csr_we=1, csr_waddr=addr, csr_wdata=new_q for exactly 1 cycle -> RESP.
  - RESP: rsp_valid=1, rsp_rdata/rsp_err stable. Hold until rsp_ready=1, then -> IDLE.
- req_ready=1 only in IDLE, so there is no overlap between requests. A response handshake followed immediately by a new request adds 1 idle cycle.
- Latency from the acceptance edge to rsp_valid:
  - full read-modify-write: 4 cycles
  - read-only: 3 cycles
  - write-only: 2 cycles
  - error: 1 cycle
- Ordering: a write completes before the next request's read, so back-to-back accesses to the same CSR return the updated value.
- csr_re and csr_we are never asserted in the same cycle. Each is asserted at most once per request.
- rst in any state: the next cycle is IDLE, outputs are at reset values, and no further CSR access is issued. A write already sampled by the CSR file stands.

Test Plan:
- CSR 0x005=0x11; CSRRW rs1=0xA5A5, rd!=x0 -> csr_re 1 cycle after accept; csr_we with wdata 0xA5A5 at +3; rsp_valid at +4 with rsp_rdata=0x11.
- CSR 0x010=0xFF; CSRRCI zimm=0x03 -> written 0xFC, rsp_rdata=0xFF. Follow with CSRRS rs1=x0 on 0x010 -> rsp_rdata=0xFC, csr_we never asserted.
- CSRRW with rd=x0, rs1=0x1234 to 0x020 -> no csr_re, csr_we at +1, rsp_valid at +2, rsp_rdata=0.
- Errors:
  - funct3=000 -> rsp_err=1 at +1, no re/we.
  - CSRRW to 0xC00 -> rsp_err=1.
  - CSR_NUM=32 build, CSRRS rs1=x0 to 0x040 -> rsp_err=1.
- rsp_ready held low 5 cycles in RESP -> rsp_valid/rsp_rdata stable and req_ready=0 throughout; accept on rsp_ready=1, IDLE next cycle.
- rst asserted in READ state -> next cycle IDLE, csr_we never asserted, CSR contents unchanged, rsp_valid=0.
